window_reader: RTL and testbench
================================

Name: window_reader

Overview:
- Downstream consumer of the 2-bit display offset produced by the offset controller.
- Reads a 256-sample window from the 1024 x 4-bit capture RAM, starting at base address offset*256, and streams one sample per column request to the display stage.
- Latches the offset at frame start, so an offset change mid-frame never tears the displayed trace.

Parameters:
- DATA_W, 4, sample width (one bit per channel).
- WIN_W, 8, log2 of window length (256 samples).
- OFS_W, 2, offset width; ADDR_W = OFS_W + WIN_W = 10.
- RD_LAT, 1, capture RAM read latency in clocks (1..3).

Ports:
- clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- offset  in  OFS_W  window select from offset controller (0/256/512/768).
- i_frame_start  in  1  single-cycle pulse at start of display frame.
- i_col_req  in  1  single-cycle request for the next sample (one per displayed column).
- o_rd_en  out  1  capture RAM read enable.
- o_rd_addr  out  ADDR_W  capture RAM read address.
- i_rd_data  in  DATA_W  capture RAM read data, valid RD_LAT clocks after o_rd_en.
- o_sample  out  DATA_W  sample delivered to display.
- o_sample_valid  out  1  o_sample is valid this cycle.
- o_busy  out  1  window read in progress (ACTIVE or DRAIN).
- o_done  out  1  one-cycle pulse when the last sample of the window has been delivered.

Behaviour:
- Reset (i_reset low, async):
  - state = IDLE.
  - All outputs 0; latched offset 0; column counter 0; valid pipeline cleared.
- States: IDLE, ACTIVE, DRAIN.
- IDLE:
  - i_col_req ignored; o_rd_en = 0.
  - i_frame_start: off_q <= offset, cnt <= 0, go ACTIVE next clock.
- ACTIVE:
  - Each i_col_req produces o_rd_en = 1 and o_rd_addr = {off_q, cnt} in the same cycle (combinational from registered off_q/cnt); cnt <= cnt + 1.
  - Request with cnt == 255: last read; go DRAIN.
  - Without a request: o_rd_en = 0, o_rd_addr holds its last value.
- DRAIN:
  - Wait until the valid pipeline is empty.
  - On the cycle the last sample is valid: o_done = 1, then go IDLE.
  - i_col_req ignored.
- Data path:
  - RD_LAT-deep valid shift register tracks o_rd_en.
  - o_sample_valid = tail of the shift register; o_sample = i_rd_data registered with valid.
  - Delivery latency from i_col_req to o_sample_valid is exactly RD_LAT + 1 clocks.
  - Exactly 256 valid samples per completed window, in address order.
- Address arithmetic: cnt is WIN_W bits; no address leaves [off_q*256, off_q*256+255]. No wrap into the next window; the 768 window ends at 1023.
- o_busy = 1 in ACTIVE and DRAIN.
- Boundary conditions:
  - Offset changes during ACTIVE/DRAIN: no effect until the next i_frame_start.
  - i_frame_start during ACTIVE or DRAIN:
    - Restart: relatch offset, cnt <= 0, state ACTIVE.
    - Valid pipeline flushed; in-flight samples are not delivered.
    - No o_done pulse.
  - i_frame_start and i_col_req in the same cycle in IDLE: the request is ignored and the first read occurs on a later request.
  - i_frame_start and i_col_req in the same cycle in ACTIVE: restart wins; that request is dropped.
  - Reset mid-operation: immediate return to IDLE; no o_done pulse; no valid pulse after reset release until a new frame.

Optional Feature:
- Macro: WINDOW_READER_COL_EN.
- Defined:
  - Adds output port o_col (WIN_W bits), carrying the column index of the current o_sample.
  - Aligned with o_sample_valid; 0 when not valid and in reset.
  - Column index is pipelined alongside the valid shift register.
- Undefined: port and its pipeline are absent; all other behaviour is identical.

Test Plan:
- Reset, offset = 2, frame_start, then 256 col_reqs every 2nd clock -> o_rd_addr runs 512..767; 256 valids with o_sample = RAM[512..767]; o_done pulses once, 2 clocks after the last request (RD_LAT = 1); o_busy falls with return to IDLE.
- offset = 3, back-to-back col_req every clock -> addresses 768..1023 with no gaps; the last address is 1023 with no wrap to 0; o_done asserted.
- offset changed 1 -> 0 after 100 samples of a frame -> remaining addresses stay 356..511; the next frame_start reads from 0.
- frame_start reissued at sample 50 with offset = 0 -> in-flight sample suppressed; addresses restart at 0; no o_done for the aborted frame; 256 fresh valids.
- i_reset pulled low mid-ACTIVE at sample 10 -> all outputs 0 asynchronously; after release, col_reqs produce no o_rd_en until frame_start.
- RD_LAT = 3 build, with WINDOW_READER_COL_EN defined -> valid 4 clocks after each request; o_col matches the sample index 0..255.

Source files
------------

// File: rtl/window_reader_if.sv
// Capture RAM read port: window_reader drives the read request (master),
// the capture RAM returns data RD_LAT clocks later (slave).
interface window_reader_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 10
);
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    logic [DATA_W-1:0] i_rd_data;

    modport master (
        output o_rd_en,
        output o_rd_addr,
        input  i_rd_data
    );

    modport slave (
        input  o_rd_en,
        input  o_rd_addr,
        output i_rd_data
    );
endinterface

// File: rtl/window_reader.sv
// Streams a 256-sample window of the capture RAM, based at offset*256, one sample per column request.
// Optional macro WINDOW_READER_COL_EN adds o_col, the column index aligned with o_sample.
module window_reader #(
    parameter int DATA_W = 4,
    parameter int WIN_W  = 8,
    parameter int OFS_W  = 2,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic [OFS_W-1:0]  offset,
    input  logic              i_frame_start,
    input  logic              i_col_req,
    window_reader_if.master   ram,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_sample_valid,
    output logic              o_busy,
    output logic              o_done
`ifdef WINDOW_READER_COL_EN
    ,
    output logic [WIN_W-1:0]  o_col
`endif
);

    localparam int ADDR_W = OFS_W + WIN_W;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [OFS_W-1:0]   off_q;
    logic [WIN_W-1:0]   cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  rd_addr;
    logic [RD_LAT-1:0]  vld_sr;
    logic               rd_en;
    logic               tail_vld;
    logic               up_vld;
    logic               last_sample;

    // NOTE: clocked state uses <= so every register samples pre-edge values;
    // a blocking = here would let later reads in the same block see the new value.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (i_frame_start) begin
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (i_frame_start) begin
                    state_nxt = ACTIVE;
                end else if (i_col_req) begin
                    rd_en = 1'b1;
                    if (cnt == '1) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (i_frame_start) begin
                    state_nxt = ACTIVE;
                end else if (vld_sr == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The last sample of a window is the tail entry with nothing queued behind it in DRAIN.
    always_comb begin
        up_vld = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            up_vld = up_vld | vld_sr[i];
        end
    end

    assign tail_vld    = vld_sr[RD_LAT-1];
    assign last_sample = (state == DRAIN) && tail_vld && !up_vld;
    assign rd_addr     = rd_en ? {off_q, cnt} : addr_q;
    assign o_busy      = (state != IDLE);

    assign ram.o_rd_en   = rd_en;
    assign ram.o_rd_addr = rd_addr;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            off_q          <= '0;
            cnt            <= '0;
            addr_q         <= '0;
            vld_sr         <= '0;
            o_sample_valid <= 1'b0;
            o_sample       <= '0;
            o_done         <= 1'b0;
        end else begin
            addr_q <= rd_addr;

            if (i_frame_start) begin
                off_q <= offset;
                cnt   <= '0;
            end else if (rd_en) begin
                cnt <= cnt + 1'b1;
            end

            // A restart discards everything in flight, including a pending done.
            if (i_frame_start) begin
                vld_sr         <= '0;
                o_sample_valid <= 1'b0;
                o_sample       <= '0;
                o_done         <= 1'b0;
            end else begin
                vld_sr[0] <= rd_en;
                for (int i = 1; i < RD_LAT; i++) begin
                    vld_sr[i] <= vld_sr[i-1];
                end
                o_sample_valid <= tail_vld;
                o_sample       <= tail_vld ? ram.i_rd_data : '0;
                o_done         <= last_sample;
            end
        end
    end

`ifdef WINDOW_READER_COL_EN
    logic [WIN_W-1:0] col_sr [RD_LAT];

    // NOTE: the column pipeline is not reset; each stage is only used when its vld_sr bit is set.
    always_ff @(posedge clk) begin
        col_sr[0] <= cnt;
        for (int i = 1; i < RD_LAT; i++) begin
            col_sr[i] <= col_sr[i-1];
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_col <= '0;
        end else if (i_frame_start) begin
            o_col <= '0;
        end else begin
            o_col <= tail_vld ? col_sr[RD_LAT-1] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_window_reader.sv
// Directed bench for window_reader: a capture RAM model with RD_LAT read latency and an
// expected-read queue that checks every delivered sample, its latency and the done pulse.
module tb_window_reader;

    localparam int DATA_W = 4;
    localparam int WIN_W  = 8;
    localparam int OFS_W  = 2;
    localparam int ADDR_W = 10;
`ifdef WINDOW_READER_COL_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 1;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                cyc;
    } req_t;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [OFS_W-1:0]  offset;
    logic              i_frame_start;
    logic              i_col_req;
    logic [DATA_W-1:0] o_sample;
    logic              o_sample_valid;
    logic              o_busy;
    logic              o_done;
`ifdef WINDOW_READER_COL_EN
    logic [WIN_W-1:0]  o_col;
`endif

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   n_done   = 0;
    int   last_req_cyc = 0;
    int   done_cyc;
    req_t exp_q[$];
    req_t r;

    logic [DATA_W-1:0] ram [1024];
    logic [ADDR_W-1:0] a_pipe [RD_LAT];

    window_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram_if ();

    window_reader #(
        .DATA_W(DATA_W),
        .WIN_W (WIN_W),
        .OFS_W (OFS_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk           (clk),
        .i_reset       (i_reset),
        .offset        (offset),
        .i_frame_start (i_frame_start),
        .i_col_req     (i_col_req),
        .ram           (ram_if),
        .o_sample      (o_sample),
        .o_sample_valid(o_sample_valid),
        .o_busy        (o_busy),
        .o_done        (o_done)
`ifdef WINDOW_READER_COL_EN
        ,
        .o_col         (o_col)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture RAM model: address sampled each clock, data presented RD_LAT clocks later.
    always @(posedge clk) begin
        a_pipe[0] <= ram_if.o_rd_addr;
        for (int i = 1; i < RD_LAT; i++) a_pipe[i] <= a_pipe[i-1];
    end
    assign ram_if.i_rd_data = ram[a_pipe[RD_LAT-1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Delivery monitor: every valid sample must match the oldest outstanding read.
    always @(negedge clk) begin
        if (o_sample_valid === 1'b1) begin
            n_valid++;
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                check("sample", 32'(o_sample), 32'(ram[r.addr]));
                check("latency", cyc - r.cyc, RD_LAT + 1);
`ifdef WINDOW_READER_COL_EN
                check("col", 32'(o_col), 32'(r.addr[WIN_W-1:0]));
`endif
            end
        end
`ifdef WINDOW_READER_COL_EN
        else begin
            check("col_idle", 32'(o_col), 32'd0);
        end
`endif
        if (o_done === 1'b1) begin
            n_done++;
            check("done_on_last", 32'(o_sample_valid === 1'b1 && exp_q.size() == 0), 32'd1);
        end
    end

    task automatic col(input logic [ADDR_W-1:0] exp_addr, input bit exp_rd);
        i_col_req = 1'b1;
        @(negedge clk);
        check("rd_en", 32'(ram_if.o_rd_en), 32'(exp_rd));
        if (exp_rd) begin
            check("rd_addr", 32'(ram_if.o_rd_addr), 32'(exp_addr));
            exp_q.push_back(req_t'{exp_addr, cyc});
            last_req_cyc = cyc;
        end
        @(posedge clk);
        #1;
        i_col_req = 1'b0;
    endtask

    task automatic gap(input logic [ADDR_W-1:0] hold_addr);
        @(negedge clk);
        check("addr_hold", 32'(ram_if.o_rd_addr), 32'(hold_addr));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [OFS_W-1:0] ofs, input bit with_col);
        offset        = ofs;
        i_frame_start = 1'b1;
        i_col_req     = with_col;
        @(negedge clk);
        check("rd_en_on_start", 32'(ram_if.o_rd_en), 32'd0);
        @(posedge clk);
        exp_q.delete();
        n_valid = 0;
        n_done  = 0;
        #1;
        i_frame_start = 1'b0;
        i_col_req     = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 4 * RD_LAT + 8 && dcyc < 0; i++) begin
            @(negedge clk);
            if (o_done === 1'b1) dcyc = cyc;
        end
        check("done_seen", 32'(dcyc >= 0), 32'd1);
        if (dcyc >= 0) begin
            check("busy_at_done", 32'(o_busy), 32'd1);
            @(negedge clk);
            check("busy_after_done", 32'(o_busy), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic end_frame();
        check("n_valid", n_valid, 256);
        check("n_done", n_done, 1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(ram_if.o_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(ram_if.o_rd_addr), 32'd0);
        check({tag, "_sample"}, 32'(o_sample), 32'd0);
        check({tag, "_valid"}, 32'(o_sample_valid), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
`ifdef WINDOW_READER_COL_EN
        check({tag, "_col"}, 32'(o_col), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 1024; a++) begin
            logic [ADDR_W-1:0] av;
            av     = ADDR_W'(a);
            ram[a] = av[3:0] ^ av[7:4] ^ {2'b00, av[9:8]} ^ 4'h5;
        end
        i_reset       = 1'b1;
        offset        = '0;
        i_frame_start = 1'b0;
        i_col_req     = 1'b0;

        // Reset state
        #1 i_reset = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b1;
        col(10'd0, 1'b0);

        // Offset 2, frame_start with a simultaneous request, requests every 2nd clock
        frame(2'd2, 1'b1);
        check("busy_active", 32'(o_busy), 32'd1);
        for (int i = 0; i < 256; i++) begin
            col(ADDR_W'(512 + i), 1'b1);
            gap(ADDR_W'(512 + i));
        end
        wait_done(done_cyc);
        check("done_latency", done_cyc - last_req_cyc, RD_LAT + 1);
        end_frame();

        // Offset 3, back-to-back requests up to address 1023
        frame(2'd3, 1'b0);
        for (int i = 0; i < 256; i++) col(ADDR_W'(768 + i), 1'b1);
        wait_done(done_cyc);
        end_frame();
        for (int i = 0; i < 3; i++) col(10'd0, 1'b0);
        idle(RD_LAT + 2);
        check("idle_no_valid", n_valid, 256);

        // Offset changed mid-frame has no effect
        frame(2'd1, 1'b0);
        for (int i = 0; i < 100; i++) col(ADDR_W'(256 + i), 1'b1);
        offset = 2'd0;
        for (int i = 100; i < 256; i++) col(ADDR_W'(256 + i), 1'b1);
        wait_done(done_cyc);
        end_frame();

        // Restart at sample 50 with a simultaneous request
        frame(2'd0, 1'b0);
        for (int i = 0; i < 50; i++) col(ADDR_W'(i), 1'b1);
        check("no_done_before_abort", n_done, 0);
        frame(2'd0, 1'b1);
        idle(RD_LAT + 2);
        check("flushed_no_valid", n_valid, 0);
        for (int i = 0; i < 256; i++) col(ADDR_W'(i), 1'b1);
        wait_done(done_cyc);
        end_frame();

        // Asynchronous reset at sample 10
        frame(2'd0, 1'b0);
        for (int i = 0; i < 10; i++) col(ADDR_W'(i), 1'b1);
        i_col_req = 1'b1;
        #2 i_reset = 1'b0;
        exp_q.delete();
        #1 check_all_zero("async_reset");
        i_col_req = 1'b0;
        n_valid   = 0;
        n_done    = 0;
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b1;
        for (int i = 0; i < 4; i++) col(10'd0, 1'b0);
        idle(RD_LAT + 2);
        check("post_reset_valid", n_valid, 0);
        check("post_reset_done", n_done, 0);

        // Normal frame after reset
        frame(2'd1, 1'b0);
        for (int i = 0; i < 256; i++) col(ADDR_W'(256 + i), 1'b1);
        wait_done(done_cyc);
        end_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
